// File: rtl/controller_sequencer_if.sv
// controller_sequencer_if
//   Bundles the sequencer's decode input and control outputs.
//   opcode        4   IR bits [7:4] (driven by the IR side)
//   t_state       6   one-hot ring state, bit0=T1 .. bit5=T6
//   halted        1   set by HLT, cleared only by reset
//   control_word  12  {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
//   master: the sequencer. slave: the datapath / IR side.
interface controller_sequencer_if;
  logic [3:0]  opcode;
  logic [5:0]  t_state;
  logic        halted;
  logic [11:0] control_word;

  modport master (input opcode, output t_state, halted, control_word);
  modport slave  (output opcode, input t_state, halted, control_word);
endinterface

// File: rtl/controller_sequencer.sv
// controller_sequencer
//   SAP-1 control unit: 6-state one-hot ring counter (T1..T6) plus opcode
//   decoder producing the 12-bit control word. Supports LDA/ADD/SUB/OUT/HLT.
//   Ports:
//     clk    in  system clock, rising edge
//     clr_n  in  asynchronous active-low reset
//     bus    controller_sequencer_if.master (opcode in; t_state, halted,
//            control_word out)
//   Build option:
//     EARLY_END_EN  when defined, the ring returns to T1 right after the last
//                   active execute state (OUT/undefined: 4 clocks, LDA: 5,
//                   ADD/SUB: 6). When undefined every instruction takes 6.
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic                     clk,
  input  logic                     clr_n,
  controller_sequencer_if.master   bus
);

`ifdef EARLY_END_EN
  localparam bit EARLY_END = 1'b1;
`else
  localparam bit EARLY_END = 1'b0;
`endif

  // control word bit positions, bit11=cp .. bit0=lo
  localparam logic [11:0] CP = 12'h800;
  localparam logic [11:0] EP = 12'h400;
  localparam logic [11:0] LM = 12'h200;
  localparam logic [11:0] CE = 12'h100;
  localparam logic [11:0] LI = 12'h080;
  localparam logic [11:0] EI = 12'h040;
  localparam logic [11:0] LA = 12'h020;
  localparam logic [11:0] EA = 12'h010;
  localparam logic [11:0] SU = 12'h008;
  localparam logic [11:0] EU = 12'h004;
  localparam logic [11:0] LB = 12'h002;
  localparam logic [11:0] LO = 12'h001;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e    state_q;
  logic        halted_q;
  logic [11:0] cw;
  logic        op_known;

  assign op_known = (bus.opcode == OP_LDA) || (bus.opcode == OP_ADD) ||
                    (bus.opcode == OP_SUB) || (bus.opcode == OP_OUT) ||
                    (bus.opcode == OP_HLT);

  // Ring counter and halt flag. HLT parks the ring at T4 with halted set;
  // only clr_n can release it.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      case (state_q)
        T1: state_q <= T2;
        T2: state_q <= T3;
        T3: state_q <= T4;
        T4: begin
          if (bus.opcode == OP_HLT)
            halted_q <= 1'b1;
          else if (EARLY_END && ((bus.opcode == OP_OUT) || !op_known))
            state_q <= T1;
          else
            state_q <= T5;
        end
        T5: begin
          if (EARLY_END && (bus.opcode == OP_LDA))
            state_q <= T1;
          else
            state_q <= T6;
        end
        T6:      state_q <= T1;
        default: state_q <= T1; // non-one-hot recovery
      endcase
    end
  end

  // Decoder: purely combinational from the registered state, so the word
  // tracks t_state with no extra cycle.
  always_comb begin
    cw = '0;
    if (!halted_q) begin
      case (state_q)
        T1: cw = EP | LM;
        T2: cw = CP;
        T3: cw = CE | LI;
        T4: begin
          if ((bus.opcode == OP_LDA) || (bus.opcode == OP_ADD) ||
              (bus.opcode == OP_SUB))
            cw = EI | LM;
          else if (bus.opcode == OP_OUT)
            cw = EA | LO;
        end
        T5: begin
          if (bus.opcode == OP_LDA)
            cw = CE | LA;
          else if ((bus.opcode == OP_ADD) || (bus.opcode == OP_SUB))
            cw = CE | LB;
        end
        T6: begin
          if (bus.opcode == OP_ADD)
            cw = EU | LA;
          else if (bus.opcode == OP_SUB)
            cw = SU | EU | LA;
        end
        default: cw = '0;
      endcase
    end
  end

  assign bus.t_state      = state_q;
  assign bus.halted       = halted_q;
  assign bus.control_word = cw;

endmodule
